// File: rtl/if_id_hazard.sv
// if_id_hazard: IF/ID register with load-use stall and branch/jump flush, updated on the falling clock edge.
// Define IF_ID_HAZARD_CNT_EN to add saturating stall/flush event counters.
module if_id_hazard #(
  parameter int CNT_W = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_plus4_i,
  input  logic        branch_taken_i,
  input  logic        jump_i,
  input  logic        idex_memread_i,
  input  logic [4:0]  idex_rt_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus4_o,
  output logic        valid_o,
  output logic        pc_write_o,
  output logic        ctrl_zero_o
`ifdef IF_ID_HAZARD_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
`endif
);
  logic stall, flush;
  if (CNT_W < 1) begin : g_bad_w
    $error("CNT_W must be positive");
  end
  always_comb begin
    stall = valid_o & idex_memread_i & (idex_rt_i != 5'd0) &
            ((idex_rt_i == instr_o[25:21]) | (idex_rt_i == instr_o[20:16]));
    flush = (branch_taken_i | jump_i) & ~stall;
    pc_write_o = ~stall;
    ctrl_zero_o = stall;
  end
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      instr_o <= '0;
      pc_plus4_o <= '0;
      valid_o <= 1'b0;
    end else if (!stall) begin
      instr_o <= flush ? '0 : instr_i;
      pc_plus4_o <= pc_plus4_i;
      valid_o <= ~flush;
    end
  end
`ifdef IF_ID_HAZARD_CNT_EN
  always_ff @(negedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall && !(&stall_cnt_o)) stall_cnt_o <= stall_cnt_o + 1'b1;
      if (flush && !(&flush_cnt_o)) flush_cnt_o <= flush_cnt_o + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_if_id_hazard.sv
// tb_if_id_hazard: directed and randomized checks of if_id_hazard against a behavioural pipeline model.
module tb_if_id_hazard;
  localparam int CNT_W = 16;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic        clk_i = 1'b0, rst_n_i = 1'b0;
  logic [31:0] instr_i = '0, pc_plus4_i = '0;
  logic        branch_taken_i = 1'b0, jump_i = 1'b0, idex_memread_i = 1'b0;
  logic [4:0]  idex_rt_i = '0;
  logic [31:0] instr_o, pc_plus4_o;
  logic        valid_o, pc_write_o, ctrl_zero_o;
`ifdef IF_ID_HAZARD_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o, flush_cnt_o;
`endif
  int checks = 0, errors = 0;
  logic [31:0] m_instr = '0, m_pc = '0;
  logic        m_valid = 1'b0;
  int          m_stalls = 0, m_flushes = 0;

  if_id_hazard #(.CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .instr_i(instr_i), .pc_plus4_i(pc_plus4_i),
    .branch_taken_i(branch_taken_i), .jump_i(jump_i), .idex_memread_i(idex_memread_i),
    .idex_rt_i(idex_rt_i), .instr_o(instr_o), .pc_plus4_o(pc_plus4_o), .valid_o(valid_o),
    .pc_write_o(pc_write_o), .ctrl_zero_o(ctrl_zero_o)
`ifdef IF_ID_HAZARD_CNT_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit hazard(input logic [4:0] rt, input bit mr);
    logic [31:0] w = m_instr;
    return m_valid && mr && rt != 0 && (rt == w[25:21] || rt == w[20:16]);
  endfunction

  task automatic model_reset();
    m_instr = '0; m_pc = '0; m_valid = 1'b0; m_stalls = 0; m_flushes = 0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".instr"}, instr_o, m_instr);
    chk({tag, ".pc"}, pc_plus4_o, m_pc);
    chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, m_valid});
`ifdef IF_ID_HAZARD_CNT_EN
    chk({tag, ".scnt"}, {16'd0, stall_cnt_o}, (m_stalls > CNT_MAX) ? CNT_MAX : m_stalls);
    chk({tag, ".fcnt"}, {16'd0, flush_cnt_o}, (m_flushes > CNT_MAX) ? CNT_MAX : m_flushes);
`endif
  endtask

  // Drive one cycle's inputs (called just after a rising edge), check hazard outputs, then the registered result.
  task automatic apply(input string tag, input logic [31:0] ins, input logic [31:0] pc,
                       input bit br, input bit jmp, input bit mr, input logic [4:0] rt);
    bit st, fl;
    instr_i = ins; pc_plus4_i = pc; branch_taken_i = br; jump_i = jmp;
    idex_memread_i = mr; idex_rt_i = rt;
    st = hazard(rt, mr);
    fl = (br || jmp) && !st;
    #1;
    chk({tag, ".pcw"}, {31'd0, pc_write_o}, {31'd0, !st});
    chk({tag, ".cz"}, {31'd0, ctrl_zero_o}, {31'd0, st});
    @(negedge clk_i);
    if (st) m_stalls++;
    else begin
      if (fl) m_flushes++;
      m_instr = fl ? 32'd0 : ins;
      m_pc = pc;
      m_valid = !fl;
    end
    @(posedge clk_i);
    #1;
    chk_state(tag);
  endtask

  initial begin
    logic [31:0] ri;
    logic [4:0]  rrt;
    instr_i = 32'h8C220004;
    repeat (2) @(posedge clk_i);
    #1;
    model_reset();
    chk_state("reset");
    chk("reset.pcw", {31'd0, pc_write_o}, 32'd1);
    chk("reset.cz", {31'd0, ctrl_zero_o}, 32'd0);
    rst_n_i = 1'b1;
    apply("pass", 32'h8C220004, 32'h4, 0, 0, 0, 5'd0);
    chk("pass.const", instr_o, 32'h8C220004);
    apply("ld_use_a", 32'h00411820, 32'h8, 0, 0, 0, 5'd0);
    apply("ld_use_st", 32'h11111111, 32'hC, 1, 0, 1, 5'd2);
    chk("ld_use.hold", instr_o, 32'h00411820);
    apply("ld_use_adv", 32'h11111111, 32'hC, 0, 0, 0, 5'd2);
    chk("ld_use.adv", instr_o, 32'h11111111);
    apply("nfs_a", 32'h00411820, 32'h10, 0, 0, 0, 5'd0);
    apply("nfs_rt0", 32'h00411820, 32'h14, 0, 0, 1, 5'd0);
    apply("nfs_mr0", 32'h00411820, 32'h18, 0, 0, 0, 5'd1);
    apply("flush_br", 32'h00000020, 32'h1C, 1, 0, 0, 5'd0);
    chk("flush_br.nop", instr_o, 32'd0);
    apply("nfs_bub", 32'h00411820, 32'h20, 0, 0, 1, 5'd0);
    apply("flush_j", 32'h00000020, 32'h24, 0, 1, 0, 5'd0);
    chk("flush_j.v", {31'd0, valid_o}, 32'd0);
    apply("st_rt", 32'h00411820, 32'h28, 0, 0, 0, 5'd0);
    apply("st_rt_hit", 32'h0, 32'h2C, 0, 0, 1, 5'd1);
    // Reset mid-stall: state and hazard outputs must clear without a clock edge.
    idex_memread_i = 1'b1; idex_rt_i = 5'd2;
    #1;
    chk("rst_mid.pre", {31'd0, ctrl_zero_o}, 32'd1);
    rst_n_i = 1'b0;
    #1;
    model_reset();
    chk_state("rst_mid");
    chk("rst_mid.pcw", {31'd0, pc_write_o}, 32'd1);
    @(posedge clk_i);
    rst_n_i = 1'b1;
    #1;
    for (int i = 0; i < 400; i++) begin
      ri = $urandom;
      rrt = ($urandom_range(0, 2) == 0) ? m_instr[25:21] :
            ($urandom_range(0, 1) == 0) ? m_instr[20:16] : 5'($urandom);
      apply("rand", ri, $urandom, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 1) == 1, rrt);
    end
`ifdef IF_ID_HAZARD_CNT_EN
    apply("sat_a", 32'h00411820, 32'h40, 0, 0, 0, 5'd0);
    instr_i = 32'h0; branch_taken_i = 1'b1; jump_i = 1'b0; idex_memread_i = 1'b1; idex_rt_i = 5'd1;
    repeat (CNT_MAX + 5) @(negedge clk_i);
    m_stalls += CNT_MAX + 5;
    @(posedge clk_i);
    #1;
    chk_state("sat");
    chk("sat.all1", {16'd0, stall_cnt_o}, CNT_MAX);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
